// File: rtl/morse_decoder.sv
// Serial Morse symbol decoder: captures a left-aligned symbol word until a run of
// GAP_LEN zero ticks (or 16 symbols), then looks it up in a fixed 8-entry table.
module morse_decoder #(
   parameter int unsigned GAP_LEN = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       bit_in,
   output logic [2:0] letter,
   output logic       valid,
   output logic       error,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StRecv, StDecode} state_t;

   localparam logic [3:0] GapCount = 4'(GAP_LEN);

   state_t      state_q, state_d;
   logic [15:0] capture_q, capture_d;
   logic [4:0]  bit_count_q, bit_count_d;
   logic [3:0]  zero_run_q, zero_run_d;
   logic        overflow_q, overflow_d;
   logic [2:0]  letter_q, letter_d;
   logic        valid_q, valid_d;
   logic        error_q, error_d;
   logic        match_found;
   logic [2:0]  match_code;

   function automatic logic [15:0] pattern(input logic [2:0] code);
      logic [15:0] p;
      case (code)
         3'd0:    p = 16'b1010_1000_0000_0000;
         3'd1:    p = 16'b1110_0000_0000_0000;
         3'd2:    p = 16'b1010_1110_0000_0000;
         3'd3:    p = 16'b1010_1011_1000_0000;
         3'd4:    p = 16'b1011_1011_1000_0000;
         3'd5:    p = 16'b1110_1010_1110_0000;
         3'd6:    p = 16'b1110_1010_1110_0000;
         default: p = 16'b1110_1011_1011_1000;
      endcase
      return p;
   endfunction

   // Scan downwards so the lowest matching code is the one left standing.
   always_comb begin
      match_found = 1'b0;
      match_code  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (capture_q == pattern(3'(i))) begin
            match_found = 1'b1;
            match_code  = 3'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      capture_d   = capture_q;
      bit_count_d = bit_count_q;
      zero_run_d  = zero_run_q;
      overflow_d  = overflow_q;
      letter_d    = letter_q;
      valid_d     = 1'b0;
      error_d     = 1'b0;
      case (state_q)
         StIdle: begin
            if (enable && bit_in) begin
               capture_d   = 16'h8000;
               bit_count_d = 5'd1;
               zero_run_d  = 4'd0;
               overflow_d  = 1'b0;
               state_d     = StRecv;
            end
         end
         StRecv: begin
            if (enable) begin
               capture_d[4'd15 - bit_count_q[3:0]] = bit_in;
               bit_count_d = bit_count_q + 5'd1;
               zero_run_d  = bit_in ? 4'd0 : zero_run_q + 4'd1;
               // A gap completing on the 16th symbol is a normal letter end.
               if (zero_run_d == GapCount) begin
                  state_d    = StDecode;
                  overflow_d = 1'b0;
               end else if (bit_count_d == 5'd16) begin
                  state_d    = StDecode;
                  overflow_d = 1'b1;
               end
            end
         end
         StDecode: begin
            state_d = StIdle;
            if (match_found && !overflow_q) begin
               letter_d = match_code;
               valid_d  = 1'b1;
            end else begin
               error_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         capture_q   <= 16'd0;
         bit_count_q <= 5'd0;
         zero_run_q  <= 4'd0;
         overflow_q  <= 1'b0;
         letter_q    <= 3'd0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         capture_q   <= capture_d;
         bit_count_q <= bit_count_d;
         zero_run_q  <= zero_run_d;
         overflow_q  <= overflow_d;
         letter_q    <= letter_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign letter = letter_q;
   assign valid  = valid_q;
   assign error  = error_q;
   assign busy   = (state_q != StIdle);

endmodule
